// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM state
// encoding, frame length and a width helper.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

    // Start bit, eight data bits and two stop bits.
    localparam int FRAME_BITS = 11;

    // Number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake plus the shift-register send/status link.
// The scheduler uses the master side; requesters and the shift register sit on slave.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        input  req_valid, req_data, tx_active, tx_done,
        output req_ack, tx_data, tx_send
    );

    modport slave (
        output req_valid, req_data, tx_active, tx_done,
        input  req_ack, tx_data, tx_send
    );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap and
// returns the first requesting index as both a one-hot vector and a binary index.
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          grant,
    output logic [clog2(N)-1:0]   idx,
    output logic                  any
);
    localparam int IDW = clog2(N);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        logic [IDW-1:0] cand;
        cand = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = N; k >= 1; k--) begin
            cand = IDW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign grant[gi] = any && (idx == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmit shift register among NUM_REQ
// byte sources, with inter-frame gap and a sticky stalled-transmitter flag.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 4
) (
    input  logic                        baud_clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        err_clr,
    uart_tx_sched_if.master             bus,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int         IDW      = clog2(NUM_REQ);
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t         state_reg;
    logic [IDW-1:0]       ptr_reg;
    logic [IDW-1:0]       grant_id_reg;
    logic [3:0]           tmo_cnt_reg;
    logic [3:0]           gap_cnt_reg;
    logic [7:0]           tx_data_reg;
    logic                 tx_send_reg;
    logic [NUM_REQ-1:0]   req_ack_reg;
    logic                 busy_reg;
    logic                 timeout_err_reg;

    logic [7:0]           req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= IDW'(NUM_REQ - 1);
            grant_id_reg    <= '0;
            tmo_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            tx_data_reg     <= 8'h00;
            tx_send_reg     <= 1'b0;
            req_ack_reg     <= '0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            req_ack_reg <= '0;
            // A timeout set later in this block overrides a same-cycle clear.
            if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (enable && arb_any) begin
                        tx_data_reg  <= req_bytes[arb_idx];
                        req_ack_reg  <= arb_grant;
                        grant_id_reg <= arb_idx;
                        ptr_reg      <= arb_idx;
                        tx_send_reg  <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    tmo_cnt_reg <= tmo_cnt_reg + 4'd1;
                    if (bus.tx_active) begin
                        tx_send_reg <= 1'b0;
                        state_reg   <= WAIT_DONE;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        // Stalled transmitter: the acked byte is dropped.
                        tx_send_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_done && !bus.tx_active) begin
                        if (GAP_CYCLES == 0) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            gap_cnt_reg <= '0;
                            state_reg   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    tx_send_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack  = req_ack_reg;
    assign bus.tx_data  = tx_data_reg;
    assign bus.tx_send  = tx_send_reg;
    assign grant_id     = grant_id_reg;
    assign busy         = busy_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: three instances (gap 1, 0, 3) with shift-register
// models; instance 0 is scored against a transaction-level timing model.
module tb_uart_tx_sched;

    localparam int NR       = 4;
    localparam int TMO      = 4;
    localparam int GAP_MAIN = 1;
    localparam int NFB      = uart_tx_sched_pkg::FRAME_BITS;

    logic             baud_clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             err_clr;
    logic             stall;
    logic [NR-1:0]    req_valid;
    logic [8*NR-1:0]  req_data;
    int               cyc = 0;

    always #5 baud_clk = ~baud_clk;
    always @(posedge baud_clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int GAPV = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
            uart_tx_sched_if #(.NUM_REQ(NR)) bus ();
            logic [1:0] grant_id;
            logic       busy;
            logic       timeout_err;

            uart_tx_sched #(
                .NUM_REQ    (NR),
                .GAP_CYCLES (GAPV),
                .TIMEOUT    (TMO)
            ) dut (
                .baud_clk    (baud_clk),
                .reset_n     (reset_n),
                .enable      (enable),
                .err_clr     (err_clr),
                .bus         (bus),
                .grant_id    (grant_id),
                .busy        (busy),
                .timeout_err (timeout_err)
            );

            assign bus.req_valid = req_valid;
            assign bus.req_data  = req_data;

            // Shift register model: loads on the first edge it sees tx_send,
            // then presents one frame bit per cycle.
            logic        sr_active;
            logic        sr_done;
            logic [10:0] sr_shift;
            int          sr_cnt;
            always @(posedge baud_clk or negedge reset_n) begin
                if (!reset_n) begin
                    sr_active <= 1'b0;
                    sr_done   <= 1'b1;
                    sr_shift  <= '1;
                    sr_cnt    <= 0;
                end else if (!sr_active) begin
                    if (bus.tx_send && !stall) begin
                        sr_active <= 1'b1;
                        sr_done   <= 1'b0;
                        sr_shift  <= {2'b11, bus.tx_data, 1'b0};
                        sr_cnt    <= NFB;
                    end
                end else if (sr_cnt == 1) begin
                    sr_active <= 1'b0;
                    sr_done   <= 1'b1;
                    sr_shift  <= '1;
                end else begin
                    sr_cnt   <= sr_cnt - 1;
                    sr_shift <= {1'b1, sr_shift[10:1]};
                end
            end
            assign bus.tx_active = sr_active;
            assign bus.tx_done   = sr_done;

            // Cycles from the edge that sees tx_done to the rise of tx_send.
            logic done_q = 1'b1;
            logic send_q = 1'b0;
            int   t_done = -1;
            int   meas   = -1;
            always @(negedge baud_clk) begin
                if (bus.tx_done && !done_q) t_done <= cyc;
                if (bus.tx_send && !send_q && t_done >= 0) meas <= cyc - t_done - 1;
                done_q <= bus.tx_done;
                send_q <= bus.tx_send;
            end
        end
    endgenerate

    logic [NR-1:0] ack0;
    logic [7:0]    txd0;
    logic          send0, busy0, err0, active0, ser0;
    logic [1:0]    gid0;
    assign ack0    = g_dut[0].bus.req_ack;
    assign txd0    = g_dut[0].bus.tx_data;
    assign send0   = g_dut[0].bus.tx_send;
    assign busy0   = g_dut[0].busy;
    assign err0    = g_dut[0].timeout_err;
    assign gid0    = g_dut[0].grant_id;
    assign active0 = g_dut[0].sr_active;
    assign ser0    = g_dut[0].sr_shift[0];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model of instance 0: edge index, next edge the block may
    // grant, last winner, and the windows where tx_send / timeout_err apply.
    int         e, free_at, last, grant_e, send_until, err_at;
    logic [7:0] m_tx;
    logic       m_err;

    task automatic model_reset();
        e          = 0;
        free_at    = 0;
        last       = NR - 1;
        grant_e    = -100;
        send_until = -100;
        err_at     = -100;
        m_tx       = 8'h00;
        m_err      = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(output int win);
        logic [NR-1:0] exp_ack;
        exp_ack = '0;
        win     = -1;
        e++;
        if (e >= free_at && enable && (|req_valid)) begin
            for (int k = 1; k <= NR; k++) begin
                int cand;
                cand = (last + k) % NR;
                if (win < 0 && req_valid[cand]) win = cand;
            end
            exp_ack[win] = 1'b1;
            m_tx         = req_data[8*win +: 8];
            last         = win;
            grant_e      = e;
            if (stall) begin
                send_until = e + TMO - 1;
                free_at    = e + TMO + 1;
                err_at     = e + TMO;
            end else begin
                // SEND 2 edges, WAIT_DONE 11, then the gap.
                send_until = e + 1;
                free_at    = e + 14 + GAP_MAIN;
                err_at     = -100;
            end
        end
        if (e == err_at) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        @(posedge baud_clk);
        @(negedge baud_clk);
        check_val("req_ack", 32'(ack0), 32'(exp_ack));
        check_val("tx_data", 32'(txd0), 32'(m_tx));
        check_val("tx_send", 32'(send0), 32'(e >= grant_e && e <= send_until));
        check_val("busy", 32'(busy0), 32'(e < free_at - 1));
        check_val("grant_id", 32'(gid0), 32'(last));
        check_val("timeout_err", 32'(err0), 32'(m_err));
        if (win >= 0)
            $display("txn edge %0d: grant req%0d byte %02h%s", e, win, m_tx, stall ? " stalled" : "");
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b1;
        err_clr   = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        @(negedge baud_clk);
        @(negedge baud_clk);
        check_val("rst_tx_send", 32'(send0), 0);
        check_val("rst_busy", 32'(busy0), 0);
        check_val("rst_grant_id", 32'(gid0), 0);
        check_val("rst_req_ack", 32'(ack0), 0);
        check_val("rst_tx_data", 32'(txd0), 0);
        check_val("rst_timeout_err", 32'(err0), 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int          w;
        int          n;
        int          cnt;
        int          ids [5];
        logic [7:0]  dat [5];
        logic        bits [$];
        logic [9:0]  got_bits, exp_bits;

        req_data = '0;
        do_reset();

        // Single request with serial check.
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        cycle(w);
        req_valid = '0;
        cnt = send0 ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            cycle(w);
            if (send0) cnt++;
            if (active0) bits.push_back(ser0);
        end
        check_val("single_send_cycles", 32'(cnt), 2);
        check_val("single_frame_bits", 32'(bits.size()), 32'(NFB));
        exp_bits    = '0;
        exp_bits[9] = 1'b1;
        for (int k = 0; k < 8; k++) exp_bits[k+1] = req_data[k];
        got_bits = '0;
        for (int k = 0; k < 10 && k < bits.size(); k++) got_bits[k] = bits[k];
        check_val("single_serial", 32'(got_bits), 32'(exp_bits));

        // Fairness with all four requesters held valid.
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        n = 0;
        for (int i = 0; i < 100 && n < 5; i++) begin
            cycle(w);
            if (w >= 0) begin
                ids[n] = int'(gid0);
                dat[n] = txd0;
                n++;
            end
        end
        check_val("fair_grants", 32'(n), 5);
        for (int k = 0; k < n; k++) begin
            check_val("fair_id", 32'(ids[k]), 32'(k % 4));
            check_val("fair_data", 32'(dat[k]), 32'(8'h11 * (k % 4 + 1)));
        end

        // Stalled transmitter, clear, then set racing with clear.
        do_reset();
        stall     = 1'b1;
        req_valid = 4'b0001;
        cycle(w);
        req_valid = '0;
        cnt = send0 ? 1 : 0;
        for (int i = 0; i < TMO + 2; i++) begin
            cycle(w);
            if (send0) cnt++;
        end
        check_val("stall_send_cycles", 32'(cnt), 32'(TMO));
        check_val("stall_err_set", 32'(err0), 1);
        check_val("stall_idle", 32'(busy0), 0);
        err_clr = 1'b1;
        cycle(w);
        err_clr = 1'b0;
        check_val("err_cleared", 32'(err0), 0);
        req_valid = 4'b0010;
        cycle(w);
        req_valid = '0;
        for (int i = 0; i < TMO - 1; i++) cycle(w);
        err_clr = 1'b1;
        cycle(w);
        err_clr = 1'b0;
        check_val("err_set_beats_clr", 32'(err0), 1);
        stall = 1'b0;
        for (int i = 0; i < 3; i++) cycle(w);

        // Enable dropped while a frame is in flight.
        req_data  = {8'h9C, 8'h5E, 8'h3B, 8'hC7};
        req_valid = 4'b0011;
        cycle(w);
        if (w >= 0) req_valid[w] = 1'b0;
        for (int i = 0; i < 5; i++) cycle(w);
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(w);
            if (ack0 != '0) cnt++;
        end
        check_val("disabled_acks", 32'(cnt), 0);
        enable = 1'b1;
        cycle(w);
        check_val("reenable_ack", 32'(ack0), 32'(4'b0010));
        req_valid = '0;
        for (int i = 0; i < 20; i++) cycle(w);

        // Asynchronous reset while in SEND.
        req_valid = 4'b0100;
        cycle(w);
        req_valid = '0;
        #2 reset_n = 1'b0;
        #1;
        check_val("async_tx_send", 32'(send0), 0);
        check_val("async_busy", 32'(busy0), 0);
        check_val("async_grant_id", 32'(gid0), 0);
        @(negedge baud_clk);
        reset_n = 1'b1;
        model_reset();
        req_valid = 4'b1000;
        cycle(w);
        req_valid = '0;
        check_val("post_reset_grant", 32'(gid0), 3);
        for (int i = 0; i < 20; i++) cycle(w);

        // Gap length: done-seen edge to next tx_send for gaps 1, 0 and 3.
        do_reset();
        req_data  = {8'h00, 8'h00, 8'h6D, 8'h81};
        req_valid = 4'b0011;
        cycle(w);
        req_valid[0] = 1'b0;
        for (int i = 0; i < 20; i++) cycle(w);
        req_valid = '0;
        for (int i = 0; i < 30; i++) cycle(w);
        check_val("gap1_latency", 32'(g_dut[0].meas), 32'(1 + 1));
        check_val("gap0_latency", 32'(g_dut[1].meas), 32'(1 + 0));
        check_val("gap3_latency", 32'(g_dut[2].meas), 32'(1 + 3));

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < NR; r++) begin
                if (!req_valid[r]) begin
                    if ($urandom_range(3) == 0) begin
                        req_valid[r]        = 1'b1;
                        req_data[8*r +: 8]  = 8'($urandom);
                    end
                end else if ($urandom_range(31) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            if ($urandom_range(15) == 0) enable = ~enable;
            err_clr = ($urandom_range(31) == 0);
            cycle(w);
            if (w >= 0) begin
                if ($urandom_range(1) == 0) req_valid[w] = 1'b0;
                else req_data[8*w +: 8] = 8'($urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmit shift register among NUM_REQ byte sources. Each source offers a byte with a valid/ack handshake. The scheduler grants one source, presents its byte and a send strobe to the shift register, tracks that frame through its active/done flags, enforces an inter-frame gap, and flags a stalled transmitter. It runs in the baud clock domain between the requesters and the Tx frame generator.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 1: idle baud cycles inserted after each frame, 0..15.
- TIMEOUT, 4: max baud cycles tx_send may stay high without tx_active rising, 2..15.

Ports:
- baud_clk  in  1  the only clock (baud tick clock).
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new grants.
- req_valid  in  NUM_REQ  per-requester byte-available.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle one-hot pulse: byte of that requester consumed.
- tx_data  out  8  byte to shift register, held stable for the whole frame.
- tx_send  out  1  send strobe to shift register.
- tx_active  in  1  shift register transmitting.
- tx_done  in  1  shift register idle/complete.
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky stall flag.
- err_clr  in  1  clears timeout_err.

## Operation
- States: IDLE, SEND, WAIT_DONE, GAP.
- IDLE: if enable and any req_valid, pick the winner w by round-robin, searching from ptr+1 upward with wrap. On that edge: tx_data<=req_data[w], req_ack[w]<=1, grant_id<=w, ptr<=w, tx_send<=1, tmo_cnt<=0, go SEND. Otherwise stay in IDLE with outputs unchanged.
- SEND: tx_send=1 and tmo_cnt increments.
  - tx_active=1: tx_send<=0, go WAIT_DONE.
  - tmo_cnt reaches TIMEOUT-1 with tx_active=0: tx_send<=0, timeout_err<=1, go IDLE. The byte is dropped; its ack has already been given.
- WAIT_DONE: exit when tx_done=1 and tx_active=0. Go to GAP with gap_cnt<=0, or go directly to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go IDLE.
- tx_data is held from grant until the next grant. It is never changed while busy.
- enable is sampled only in IDLE. Deasserting it mid-frame lets the frame and gap complete, then the block idles.
- A requester whose req_valid drops before it is selected is not acked. A stale req_valid during the ack cycle is ignored (the block is not in IDLE).
- timeout_err: a set and err_clr in the same cycle resolve to set.
- Unreachable state encodings go to IDLE.

## Timing
- Reset (async assert, sync release): state=IDLE, tx_send=0, tx_data=8'h00, req_ack=0, grant_id=0, busy=0, timeout_err=0, ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame aborts immediately and tx_send drops asynchronously. The shift register finishes or resets on its own.
- Grant latency: req_valid sampled at edge N; req_ack, tx_send and tx_data are valid after edge N.
- req_ack is high for exactly one cycle per grant.
- Shift register handshake: tx_active rises 2 edges after tx_send is first sampled, so TIMEOUT>=3 is required for normal operation.
- Frame occupancy: SEND 2 cycles, WAIT_DONE 11–12 cycles, then GAP_CYCLES.
- Back-to-back: with GAP_CYCLES=0, the next grant occurs on the edge after WAIT_DONE exits.
- All outputs are registered.

## Structure
- Shared package/include uart_pkg holds:
  - state encoding localparams (IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2, GAP=2'd3);
  - the FRAME_BITS=11 constant;
  - the function clog2.
- One sub-module, rr_arbiter: combinational round-robin picker. Inputs: req vector and ptr. Outputs: one-hot grant, index, any.
- FSM, counters and output registers live in uart_tx_sched.

## Test plan
- Single request: req_valid=4'b0001, req_data[7:0]=8'hA5, model shift register attached → req_ack=0001 for 1 cycle, tx_data=A5, tx_send high 2 cycles, serial out 0,1,0,1,0,0,1,0,1,1 (start bit, LSB first, no-parity stop), busy falls after the gap.
- Fairness: req_valid=4'b1111 held with distinct bytes 11/22/33/44 → grant_id sequence 0,1,2,3,0, and each tx_data matches.
- Stalled transmitter: tx_active tied 0, TIMEOUT=4 → tx_send high exactly 4 cycles, timeout_err=1, back in IDLE. err_clr pulse clears it. Simultaneous set and err_clr leaves it 1.
- Enable drop mid-frame: deassert enable during WAIT_DONE with requests pending → current frame completes, no further req_ack until enable returns.
- Async reset during SEND: reset_n low → tx_send=0, busy=0, grant_id=0 immediately. After release, req_valid=4'b1000 is granted to requester 3 on the first edge.
- GAP_CYCLES=0 vs 3: measure tx_done-high to next tx_send → 1 vs 4 cycles.
